// File: rtl/rob_retire_ctrl_pkg.sv
// Shared types and constants for the ROB retire controller: exception codes,
// FSM states and the per-slot retire record.
package rob_retire_ctrl_pkg;

  localparam int MACHINE_WIDTH = 4;
  localparam int XLEN          = 32;
  localparam int PRF_WIDTH     = 6;
  localparam int ARF_WIDTH     = 5;
  localparam int EXC_W         = 4;
  localparam int CNT_W         = $clog2(MACHINE_WIDTH + 1);

  localparam logic [PRF_WIDTH-1:0] ZERO_PRN = '0;
  localparam logic [ARF_WIDTH-1:0] ZERO_REG = '0;

  typedef enum logic [EXC_W-1:0] {
    NO_ERROR       = 4'd0,
    INSTR_MISALIGN = 4'd1,
    INSTR_FAULT    = 4'd2,
    ILLEGAL_INSTR  = 4'd3,
    BREAKPOINT     = 4'd4,
    LOAD_MISALIGN  = 4'd5,
    LOAD_FAULT     = 4'd6,
    STORE_MISALIGN = 4'd7,
    STORE_FAULT    = 4'd8,
    ECALL          = 4'd9
  } exception_code_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } retire_state_e;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [PRF_WIDTH-1:0] dest_prn;
    logic [ARF_WIDTH-1:0] dest_arn;
    logic [XLEN-1:0]      data;
    logic                 is_branch;
    logic                 branch_misp;
    exception_code_e      exception;
  } retire_slot_t;

  function automatic logic is_fault(input logic [EXC_W-1:0] code);
    return code != NO_ERROR;
  endfunction

endpackage

// File: rtl/rob_retire_ctrl_retire_select.sv
// Combinational in-order prefix scan over the oldest ROB slots: decides which
// slots retire this cycle and how many entries the ROB head advances.
module rob_retire_ctrl_retire_select
  import rob_retire_ctrl_pkg::*;
(
  input  logic                     enable,
  input  logic [MACHINE_WIDTH-1:0] ready,
  input  logic [MACHINE_WIDTH-1:0] is_store,
  input  logic [MACHINE_WIDTH-1:0] ends_group,
  output logic [MACHINE_WIDTH-1:0] retire_mask,
  output logic [CNT_W-1:0]         retire_cnt
);

  logic blocked;
  logic store_seen;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    retire_mask = '0;
    retire_cnt  = '0;
    blocked     = !enable;
    store_seen  = 1'b0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      if (!blocked && ready[i] && !(is_store[i] && store_seen)) begin
        retire_mask[i] = 1'b1;
        retire_cnt     = retire_cnt + CNT_W'(1);
        store_seen     = store_seen | is_store[i];
        // A mispredict or fault retires itself but closes the group.
        blocked        = ends_group[i];
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_retire_ctrl.sv
// Retire controller: selects the in-order retire group, drives the registered
// retire/free/STQ buses and runs the RUN/FLUSH/HALT state machine.
module rob_retire_ctrl
  import rob_retire_ctrl_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [MACHINE_WIDTH-1:0]                 head_valid,
  input  logic [MACHINE_WIDTH-1:0]                 head_complete,
  input  logic [MACHINE_WIDTH-1:0][XLEN-1:0]       head_pc,
  input  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0]  head_dest_prn,
  input  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0]  head_old_prn,
  input  logic [MACHINE_WIDTH-1:0][ARF_WIDTH-1:0]  head_dest_arn,
  input  logic [MACHINE_WIDTH-1:0][XLEN-1:0]       head_data,
  input  logic [MACHINE_WIDTH-1:0]                 head_is_branch,
  input  logic [MACHINE_WIDTH-1:0]                 head_branch_misp,
  input  logic [MACHINE_WIDTH-1:0]                 head_is_store,
  input  logic [MACHINE_WIDTH-1:0][EXC_W-1:0]      head_exception,
  output logic [CNT_W-1:0]                         rob_retire_cnt,
  output logic [MACHINE_WIDTH-1:0]                 free_valid,
  output logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0]  free_prn,
  output logic                                     stq_retire,
  output logic [MACHINE_WIDTH-1:0]                 retire_valid,
  output logic [MACHINE_WIDTH-1:0][XLEN-1:0]       retire_pc,
  output logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0]  retire_dest_prn,
  output logic [MACHINE_WIDTH-1:0][ARF_WIDTH-1:0]  retire_dest_arn,
  output logic [MACHINE_WIDTH-1:0][XLEN-1:0]       retire_data,
  output logic [MACHINE_WIDTH-1:0]                 retire_is_branch,
  output logic [MACHINE_WIDTH-1:0]                 retire_branch_misp,
  output logic [MACHINE_WIDTH-1:0][EXC_W-1:0]      retire_exception,
  output logic                                     flush,
  output logic                                     halt
);

  retire_state_e state_q, state_d;
  retire_slot_t [MACHINE_WIDTH-1:0] slots_q, slots_d;
  logic [MACHINE_WIDTH-1:0] retire_valid_q, retire_valid_d;
  logic [MACHINE_WIDTH-1:0] free_valid_q, free_valid_d;
  logic [MACHINE_WIDTH-1:0][PRF_WIDTH-1:0] free_prn_q, free_prn_d;
  logic stq_retire_q, stq_retire_d;
  logic flush_q, flush_d;
  logic halt_q, halt_d;

  logic [MACHINE_WIDTH-1:0] ready, ends_group, retire_mask;
  logic [CNT_W-1:0]         sel_cnt;
  logic                     exc_hit, misp_hit;

  always_comb begin
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      ready[i]      = head_valid[i] & head_complete[i];
      ends_group[i] = head_branch_misp[i] | is_fault(head_exception[i]);
    end
  end

  rob_retire_ctrl_retire_select u_select (
    .enable      (state_q == ST_RUN),
    .ready       (ready),
    .is_store    (head_is_store),
    .ends_group  (ends_group),
    .retire_mask (retire_mask),
    .retire_cnt  (sel_cnt)
  );

  assign rob_retire_cnt = sel_cnt;

  always_comb begin
    state_d        = state_q;
    slots_d        = slots_q;
    retire_valid_d = '0;
    free_valid_d   = '0;
    free_prn_d     = free_prn_q;
    stq_retire_d   = 1'b0;
    flush_d        = 1'b0;
    halt_d         = halt_q;
    exc_hit        = 1'b0;
    misp_hit       = 1'b0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      if (retire_mask[i]) begin
        retire_valid_d[i] = 1'b1;
        slots_d[i] = '{pc: head_pc[i], dest_prn: head_dest_prn[i], dest_arn: head_dest_arn[i],
                       data: head_data[i], is_branch: head_is_branch[i],
                       branch_misp: head_branch_misp[i],
                       exception: exception_code_e'(head_exception[i])};
        free_prn_d[i] = head_old_prn[i];
        if (is_fault(head_exception[i])) begin
          exc_hit = 1'b1;
        end else begin
          misp_hit        = misp_hit | head_branch_misp[i];
          free_valid_d[i] = head_dest_prn[i] != ZERO_PRN;
          stq_retire_d    = stq_retire_d | head_is_store[i];
        end
      end
    end
    unique case (state_q)
      ST_RUN: begin
        if (exc_hit) begin
          state_d = ST_HALT;
          flush_d = 1'b1;
          halt_d  = 1'b1;
        end else if (misp_hit) begin
          state_d = ST_FLUSH;
          flush_d = 1'b1;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // data fields are reset too, so retire_exception reads NO_ERROR out of reset.
    if (rst) begin
      state_q        <= ST_RUN;
      slots_q        <= '0;
      retire_valid_q <= '0;
      free_valid_q   <= '0;
      free_prn_q     <= '0;
      stq_retire_q   <= 1'b0;
      flush_q        <= 1'b0;
      halt_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      slots_q        <= slots_d;
      retire_valid_q <= retire_valid_d;
      free_valid_q   <= free_valid_d;
      free_prn_q     <= free_prn_d;
      stq_retire_q   <= stq_retire_d;
      flush_q        <= flush_d;
      halt_q         <= halt_d;
    end
  end

  assign retire_valid = retire_valid_q;
  assign free_valid   = free_valid_q;
  assign free_prn     = free_prn_q;
  assign stq_retire   = stq_retire_q;
  assign flush        = flush_q;
  assign halt         = halt_q;

  for (genvar g = 0; g < MACHINE_WIDTH; g++) begin : g_slot_out
    assign retire_pc[g]          = slots_q[g].pc;
    assign retire_dest_prn[g]    = slots_q[g].dest_prn;
    assign retire_dest_arn[g]    = slots_q[g].dest_arn;
    assign retire_data[g]        = slots_q[g].data;
    assign retire_is_branch[g]   = slots_q[g].is_branch;
    assign retire_branch_misp[g] = slots_q[g].branch_misp;
    assign retire_exception[g]   = slots_q[g].exception;
  end

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Bench for rob_retire_ctrl: directed scenarios with hand-derived expectations,
// then randomized traffic checked against a behavioural retire model.
module tb_rob_retire_ctrl;
  import rob_retire_ctrl_pkg::*;

  localparam int W = MACHINE_WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] head_valid, head_complete, head_is_branch, head_branch_misp, head_is_store;
  logic [W-1:0][XLEN-1:0] head_pc, head_data;
  logic [W-1:0][PRF_WIDTH-1:0] head_dest_prn, head_old_prn;
  logic [W-1:0][ARF_WIDTH-1:0] head_dest_arn;
  logic [W-1:0][EXC_W-1:0] head_exception;

  logic [CNT_W-1:0] rob_retire_cnt;
  logic [W-1:0] free_valid, retire_valid, retire_is_branch, retire_branch_misp;
  logic [W-1:0][PRF_WIDTH-1:0] free_prn, retire_dest_prn;
  logic [W-1:0][XLEN-1:0] retire_pc, retire_data;
  logic [W-1:0][ARF_WIDTH-1:0] retire_dest_arn;
  logic [W-1:0][EXC_W-1:0] retire_exception;
  logic stq_retire, flush, halt;

  int checks = 0;
  int failures = 0;

  rob_retire_ctrl dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_complete(head_complete), .head_pc(head_pc),
    .head_dest_prn(head_dest_prn), .head_old_prn(head_old_prn), .head_dest_arn(head_dest_arn),
    .head_data(head_data), .head_is_branch(head_is_branch), .head_branch_misp(head_branch_misp),
    .head_is_store(head_is_store), .head_exception(head_exception),
    .rob_retire_cnt(rob_retire_cnt), .free_valid(free_valid), .free_prn(free_prn),
    .stq_retire(stq_retire), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_dest_prn(retire_dest_prn), .retire_dest_arn(retire_dest_arn),
    .retire_data(retire_data), .retire_is_branch(retire_is_branch),
    .retire_branch_misp(retire_branch_misp), .retire_exception(retire_exception),
    .flush(flush), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_heads();
    head_valid = '0; head_complete = '0; head_is_branch = '0; head_branch_misp = '0;
    head_is_store = '0; head_pc = '0; head_data = '0; head_dest_prn = '0;
    head_old_prn = '0; head_dest_arn = '0; head_exception = '0;
  endtask

  // All slots valid and complete, no events, distinct non-zero registers.
  task automatic fill_ready();
    clear_heads();
    for (int i = 0; i < W; i++) begin
      head_valid[i]    = 1'b1;
      head_complete[i] = 1'b1;
      head_pc[i]       = 32'h1000 + 32'(4 * i);
      head_dest_prn[i] = PRF_WIDTH'(8 + i);
      head_old_prn[i]  = PRF_WIDTH'(32 + i);
      head_dest_arn[i] = ARF_WIDTH'(i + 1);
      head_data[i]     = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_heads();
    tick();
    tick();
    checks++; if (retire_valid !== 4'b0000) begin failures++; $display("FAIL reset_retire_valid got=%b exp=0000", retire_valid); end
    checks++; if (free_valid !== 4'b0000) begin failures++; $display("FAIL reset_free_valid got=%b exp=0000", free_valid); end
    checks++; if ({flush, halt, stq_retire} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {flush, halt, stq_retire}); end
    checks++; if (retire_exception !== '0) begin failures++; $display("FAIL reset_exception got=%h exp=all NO_ERROR", retire_exception); end
    rst = 1'b0;
  endtask

  task automatic test_all_ready();
    fill_ready();
    head_dest_prn[0] = ZERO_PRN;
    #1;
    checks++; if (rob_retire_cnt !== 3'd4) begin failures++; $display("FAIL all_ready_cnt got=%0d exp=4", rob_retire_cnt); end
    tick();
    checks++; if (retire_valid !== 4'b1111) begin failures++; $display("FAIL all_ready_retire_valid got=%b exp=1111", retire_valid); end
    checks++; if (free_valid !== 4'b1110) begin failures++; $display("FAIL all_ready_free_valid got=%b exp=1110", free_valid); end
    checks++; if (free_prn[2] !== 6'd34) begin failures++; $display("FAIL all_ready_free_prn2 got=%0d exp=34", free_prn[2]); end
    checks++; if (retire_pc[3] !== 32'h100C) begin failures++; $display("FAIL all_ready_pc3 got=%h exp=100c", retire_pc[3]); end
    checks++; if ({flush, stq_retire} !== 2'b00) begin failures++; $display("FAIL all_ready_flags got=%b exp=00", {flush, stq_retire}); end
    clear_heads();
  endtask

  task automatic test_hole();
    fill_ready();
    head_complete = 4'b1011;
    #1;
    checks++; if (rob_retire_cnt !== 3'd2) begin failures++; $display("FAIL hole_cnt got=%0d exp=2", rob_retire_cnt); end
    tick();
    checks++; if (retire_valid !== 4'b0011) begin failures++; $display("FAIL hole_retire_valid got=%b exp=0011", retire_valid); end
    clear_heads();
  endtask

  task automatic test_misp();
    fill_ready();
    head_is_branch[1]   = 1'b1;
    head_branch_misp[1] = 1'b1;
    #1;
    checks++; if (rob_retire_cnt !== 3'd2) begin failures++; $display("FAIL misp_cnt got=%0d exp=2", rob_retire_cnt); end
    tick();
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL misp_flush got=%b exp=1", flush); end
    checks++; if (retire_valid !== 4'b0011) begin failures++; $display("FAIL misp_retire_valid got=%b exp=0011", retire_valid); end
    checks++; if (retire_branch_misp[1] !== 1'b1) begin failures++; $display("FAIL misp_report got=%b exp=1", retire_branch_misp[1]); end
    fill_ready();
    #1;
    checks++; if (rob_retire_cnt !== 3'd0) begin failures++; $display("FAIL misp_flush_cnt got=%0d exp=0", rob_retire_cnt); end
    tick();
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL misp_flush_pulse got=%b exp=0", flush); end
    checks++; if (retire_valid !== 4'b0000) begin failures++; $display("FAIL misp_flush_retire got=%b exp=0000", retire_valid); end
    checks++; if (rob_retire_cnt !== 3'd4) begin failures++; $display("FAIL misp_resume_cnt got=%0d exp=4", rob_retire_cnt); end
    clear_heads();
  endtask

  task automatic test_exception();
    fill_ready();
    head_exception[0] = LOAD_FAULT;
    head_is_store[0]  = 1'b1;
    #1;
    checks++; if (rob_retire_cnt !== 3'd1) begin failures++; $display("FAIL exc_cnt got=%0d exp=1", rob_retire_cnt); end
    tick();
    checks++; if (retire_valid !== 4'b0001) begin failures++; $display("FAIL exc_retire_valid got=%b exp=0001", retire_valid); end
    checks++; if (retire_exception[0] !== LOAD_FAULT) begin failures++; $display("FAIL exc_code got=%0d exp=%0d", retire_exception[0], LOAD_FAULT); end
    checks++; if ({free_valid, stq_retire} !== 5'b00000) begin failures++; $display("FAIL exc_no_free got=%b exp=00000", {free_valid, stq_retire}); end
    checks++; if ({flush, halt} !== 2'b11) begin failures++; $display("FAIL exc_flush_halt got=%b exp=11", {flush, halt}); end
    fill_ready();
    #1;
    checks++; if (rob_retire_cnt !== 3'd0) begin failures++; $display("FAIL exc_halt_cnt got=%0d exp=0", rob_retire_cnt); end
    tick();
    checks++; if ({flush, halt} !== 2'b01) begin failures++; $display("FAIL exc_halt_sticky got=%b exp=01", {flush, halt}); end
    checks++; if (retire_valid !== 4'b0000) begin failures++; $display("FAIL exc_halt_retire got=%b exp=0000", retire_valid); end
    checks++; if (rob_retire_cnt !== 3'd0) begin failures++; $display("FAIL exc_halt_cnt_later got=%0d exp=0", rob_retire_cnt); end
    clear_heads();
  endtask

  task automatic test_reset_in_halt();
    rst = 1'b1;
    tick();
    checks++; if ({flush, halt, retire_valid} !== 6'b0) begin failures++; $display("FAIL halt_rst_outputs got=%b exp=000000", {flush, halt, retire_valid}); end
    rst = 1'b0;
    fill_ready();
    #1;
    checks++; if (rob_retire_cnt !== 3'd4) begin failures++; $display("FAIL halt_rst_run_cnt got=%0d exp=4", rob_retire_cnt); end
    clear_heads();
  endtask

  task automatic test_exc_misp_same_slot();
    fill_ready();
    head_is_branch[1]   = 1'b1;
    head_branch_misp[1] = 1'b1;
    head_exception[1]   = ILLEGAL_INSTR;
    #1;
    checks++; if (rob_retire_cnt !== 3'd2) begin failures++; $display("FAIL exc_misp_cnt got=%0d exp=2", rob_retire_cnt); end
    tick();
    checks++; if ({flush, halt} !== 2'b11) begin failures++; $display("FAIL exc_misp_halt got=%b exp=11", {flush, halt}); end
    checks++; if (free_valid !== 4'b0001) begin failures++; $display("FAIL exc_misp_free got=%b exp=0001", free_valid); end
    clear_heads();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stores();
    fill_ready();
    head_is_store = 4'b0101;
    #1;
    checks++; if (rob_retire_cnt !== 3'd2) begin failures++; $display("FAIL store_cnt1 got=%0d exp=2", rob_retire_cnt); end
    tick();
    checks++; if (stq_retire !== 1'b1) begin failures++; $display("FAIL store_stq1 got=%b exp=1", stq_retire); end
    checks++; if (retire_valid !== 4'b0011) begin failures++; $display("FAIL store_retire1 got=%b exp=0011", retire_valid); end
    fill_ready();
    head_valid    = 4'b0011;
    head_is_store = 4'b0001;
    #1;
    checks++; if (rob_retire_cnt !== 3'd2) begin failures++; $display("FAIL store_cnt2 got=%0d exp=2", rob_retire_cnt); end
    tick();
    checks++; if (stq_retire !== 1'b1) begin failures++; $display("FAIL store_stq2 got=%b exp=1", stq_retire); end
    checks++; if (retire_valid !== 4'b0011) begin failures++; $display("FAIL store_retire2 got=%b exp=0011", retire_valid); end
    clear_heads();
  endtask

  task automatic test_reset_in_flush();
    fill_ready();
    head_is_branch[0]   = 1'b1;
    head_branch_misp[0] = 1'b1;
    tick();
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL flush_rst_enter got=%b exp=1", flush); end
    rst = 1'b1;
    clear_heads();
    tick();
    checks++; if ({flush, halt, retire_valid} !== 6'b0) begin failures++; $display("FAIL flush_rst_outputs got=%b exp=000000", {flush, halt, retire_valid}); end
    rst = 1'b0;
    fill_ready();
    #1;
    checks++; if (rob_retire_cnt !== 3'd4) begin failures++; $display("FAIL flush_rst_run_cnt got=%0d exp=4", rob_retire_cnt); end
    clear_heads();
  endtask

  // Model: the group ends before the first unready slot or second store, and
  // just after the first mispredict/fault; nothing retires outside RUN.
  task automatic test_random();
    int mode;  // 0 run, 1 flush, 2 halt
    bit m_halt;
    rst = 1'b1;
    clear_heads();
    tick();
    rst = 1'b0;
    mode = 0;
    m_halt = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit do_rst, exc_ev, misp_ev, exp_stq, exp_flush;
      int lim, stores;
      logic [W-1:0] exp_rv, exp_fv;
      logic [W-1:0][XLEN-1:0] exp_pc;
      logic [W-1:0][EXC_W-1:0] exp_exc;
      logic [W-1:0][PRF_WIDTH-1:0] exp_fp;
      do_rst = (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      rst = do_rst;
      for (int i = 0; i < W; i++) begin
        head_valid[i]       = $urandom_range(0, 9) != 0;
        head_complete[i]    = $urandom_range(0, 4) != 0;
        head_is_store[i]    = $urandom_range(0, 3) == 0;
        head_is_branch[i]   = $urandom_range(0, 3) == 0;
        head_branch_misp[i] = head_is_branch[i] && ($urandom_range(0, 5) == 0);
        head_exception[i]   = ($urandom_range(0, 29) == 0) ? EXC_W'($urandom_range(1, 9)) : EXC_W'(0);
        head_pc[i]          = $urandom;
        head_data[i]        = $urandom;
        head_dest_prn[i]    = ($urandom_range(0, 3) == 0) ? PRF_WIDTH'(0) : PRF_WIDTH'($urandom);
        head_old_prn[i]     = PRF_WIDTH'($urandom);
        head_dest_arn[i]    = ARF_WIDTH'($urandom);
      end
      lim = (mode == 0) ? W : 0;
      stores = 0;
      for (int i = 0; i < W; i++) begin
        if (!(head_valid[i] && head_complete[i]) && i < lim) lim = i;
        if (head_is_store[i]) begin
          stores++;
          if (stores == 2 && i < lim) lim = i;
        end
        if ((head_branch_misp[i] || head_exception[i] != 0) && i + 1 < lim) lim = i + 1;
      end
      exp_rv = '0; exp_fv = '0; exp_stq = 1'b0; exc_ev = 1'b0; misp_ev = 1'b0;
      exp_pc = retire_pc; exp_exc = retire_exception; exp_fp = free_prn;
      for (int i = 0; i < lim; i++) begin
        exp_rv[i]  = 1'b1;
        exp_pc[i]  = head_pc[i];
        exp_exc[i] = head_exception[i];
        exp_fp[i]  = head_old_prn[i];
        if (head_exception[i] != 0) exc_ev = 1'b1;
        else begin
          exp_fv[i] = head_dest_prn[i] != 0;
          if (head_is_store[i]) exp_stq = 1'b1;
          if (head_branch_misp[i]) misp_ev = 1'b1;
        end
      end
      exp_flush = exc_ev || misp_ev;
      #1;
      if (!do_rst) begin
        checks++; if (rob_retire_cnt !== CNT_W'(lim)) begin failures++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, rob_retire_cnt, lim); end
      end
      tick();
      if (do_rst) begin
        exp_rv = '0; exp_fv = '0; exp_stq = 1'b0; exp_flush = 1'b0;
        mode = 0; m_halt = 1'b0;
        checks++; if (retire_exception !== '0) begin failures++; $display("FAIL rand_rst_exc cyc=%0d got=%h exp=0", cyc, retire_exception); end
      end else begin
        m_halt = m_halt || exc_ev;
        if (mode == 0) mode = exc_ev ? 2 : (misp_ev ? 1 : 0);
        else if (mode == 1) mode = 0;
        for (int i = 0; i < W; i++) begin
          if (exp_rv[i]) begin
            checks++; if (retire_pc[i] !== exp_pc[i] || retire_exception[i] !== exp_exc[i]) begin failures++; $display("FAIL rand_slot cyc=%0d i=%0d got=%h/%0d exp=%h/%0d", cyc, i, retire_pc[i], retire_exception[i], exp_pc[i], exp_exc[i]); end
          end
          if (exp_fv[i]) begin
            checks++; if (free_prn[i] !== exp_fp[i]) begin failures++; $display("FAIL rand_free_prn cyc=%0d i=%0d got=%0d exp=%0d", cyc, i, free_prn[i], exp_fp[i]); end
          end
        end
      end
      checks++; if (retire_valid !== exp_rv) begin failures++; $display("FAIL rand_retire_valid cyc=%0d got=%b exp=%b", cyc, retire_valid, exp_rv); end
      checks++; if (free_valid !== exp_fv) begin failures++; $display("FAIL rand_free_valid cyc=%0d got=%b exp=%b", cyc, free_valid, exp_fv); end
      checks++; if ({stq_retire, flush, halt} !== {exp_stq, exp_flush, m_halt}) begin failures++; $display("FAIL rand_flags cyc=%0d got=%b exp=%b", cyc, {stq_retire, flush, halt}, {exp_stq, exp_flush, m_halt}); end
    end
    rst = 1'b0;
    clear_heads();
  endtask

  initial begin
    rst = 1'b1;
    clear_heads();
    test_reset();
    test_all_ready();
    test_hole();
    test_misp();
    test_exception();
    test_reset_in_halt();
    test_exc_misp_same_slot();
    test_stores();
    test_reset_in_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
